conv2x2_frame_ctrl: RTL and testbench
=====================================

CONV2X2_FRAME_CTRL -- requirements
Module: conv2x2_frame_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel/weight width.
REQ-002 SHALL have parameter IMG_W, default 4, frame width in pixels (>=2).
REQ-003 SHALL have parameter IMG_H, default 4, frame height in rows (>=2).
REQ-004 SHALL have parameter LAT, default 2, datapath advances from pixel accept to its window result (>=1).
REQ-005 SHALL use RES_W = 2*DATA_W+5 for result width.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 start  in  1  frame start request.
REQ-009 w_in  in  4*DATA_W  weights {w4,w3,w2,w1}, sampled on accepted start.
REQ-010 busy  out  1  high in any state except IDLE.
REQ-011 done  out  1  one-cycle frame-complete pulse.
REQ-012 s_valid / s_ready / s_pixel  in/out/in  1/1/DATA_W  raster pixel stream.
REQ-013 dp_en  out  1  datapath advance strobe.
REQ-014 dp_pixel  out  DATA_W  pixel to datapath, valid with dp_en.
REQ-015 dp_clear  out  1  one-cycle datapath line-buffer clear.
REQ-016 dp_weights  out  4*DATA_W  registered weights to datapath.
REQ-017 dp_result  in  RES_W  datapath result.
REQ-018 m_valid / m_ready / m_data  out/in/out  1/1/RES_W  result stream.
REQ-019 m_row / m_col  out  clog2(IMG_H) / clog2(IMG_W)  window top-left coordinates.

Function
REQ-020 SHALL implement states IDLE, RUN, FLUSH, DONE.
REQ-021 IDLE: start=1 -> RUN next cycle; dp_weights <= w_in; dp_clear=1 for that one cycle; row/col counters cleared.
REQ-022 start SHALL be ignored outside IDLE.
REQ-023 adv = (!m_valid || m_ready); s_ready = (state==RUN) && adv.
REQ-024 RUN: dp_en = s_valid && s_ready; dp_pixel = s_pixel; dp_en SHALL never assert with s_ready low.
REQ-025 Each RUN accept: col increments; col==IMG_W-1 wraps to 0 and row increments.
REQ-026 Accept of pixel (IMG_H-1, IMG_W-1) -> FLUSH next cycle.
REQ-027 Each dp_en SHALL push a tag {win, row-1, col-1} into a LAT-deep tag pipe advancing only on dp_en; win = (row>=1 && col>=1) of the pixel pushed.
REQ-028 Datapath contract: result for pixel k is stable on dp_result during the cycle of advance k+LAT.
REQ-029 On a dp_en edge whose emerging tag has win=1: m_data <= dp_result, m_row/m_col <= tag coords, m_valid <= 1.
REQ-030 m_valid SHALL clear on m_valid && m_ready edge unless reloaded same edge; m_data/m_row/m_col stable while m_valid && !m_ready.
REQ-031 FLUSH: exactly LAT dummy advances, each dp_en = adv, dp_pixel = 0, pushed tag win=0; after the LAT-th -> DONE.
REQ-032 DONE: hold while m_valid=1; when m_valid=0, done=1 for one cycle and -> IDLE.
REQ-033 Exactly (IMG_W-1)*(IMG_H-1) results per frame, raster order of window position; no window spans a row wrap.
REQ-034 s_valid low in RUN SHALL stall with no state, counter or tag change.

Reset
REQ-035 rst SHALL force IDLE; busy, done, s_ready, dp_en, dp_clear, m_valid = 0; dp_weights, m_data, m_row, m_col, counters, tag pipe = 0.
REQ-036 rst mid-frame SHALL discard pending tags and held result; no done pulse; next start begins a fresh frame.

Verification (behavioural datapath model: LAT=2, 2x2 weighted sum, line buffers cleared by dp_clear)
REQ-037 4x4, weights all 1, pixel(r,c)=4r+c+1, m_ready=1 -> 9 results 14,18,22,30,34,38,46,50,54 with (m_row,m_col)=(0,0)..(2,2), then single done pulse.
REQ-038 Same frame, m_ready toggling 1-in-3 -> identical sequence, no loss/duplication; s_ready low whenever m_valid && !m_ready.
REQ-039 Random s_valid gaps -> identical results; dp_en count per frame = 16+2.
REQ-040 start pulsed during RUN with different w_in -> ignored; results use original weights.
REQ-041 rst after 7 pixels, then full new frame -> no stale output, m_valid=0 until first new window, 9 correct results.
REQ-042 Weights {w1..w4}={1,2,3,4}, all pixels 255 -> every result 2550, back-to-back second frame reproduces it.

Source files
------------

// File: rtl/conv2x2_frame_ctrl.sv
// conv2x2_frame_ctrl: frame sequencer for a 2x2 convolution datapath.
// Accepts a raster pixel stream, strobes the external datapath, tracks
// window coordinates through a tag pipe that matches the datapath
// latency, and presents one result per full 2x2 window on an
// output stream with backpressure.
module conv2x2_frame_ctrl #(
    parameter  int DATA_W = 8,
    parameter  int IMG_W  = 4,
    parameter  int IMG_H  = 4,
    parameter  int LAT    = 2,
    localparam int RES_W  = 2 * DATA_W + 5,
    localparam int RW     = $clog2(IMG_H),
    localparam int CW     = $clog2(IMG_W)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DATA_W-1:0]   w_in,
    output logic                  busy,
    output logic                  done,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_W-1:0]     s_pixel,
    output logic                  dp_en,
    output logic [DATA_W-1:0]     dp_pixel,
    output logic                  dp_clear,
    output logic [4*DATA_W-1:0]   dp_weights,
    input  logic [RES_W-1:0]      dp_result,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [RES_W-1:0]      m_data,
    output logic [RW-1:0]         m_row,
    output logic [CW-1:0]         m_col
);

    localparam int FW = $clog2(LAT + 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state;
    logic [RW-1:0]           row;
    logic [CW-1:0]           col;
    logic [FW-1:0]           flush_cnt;
    logic [LAT-1:0]          tag_win;
    logic [LAT-1:0][RW-1:0]  tag_row;
    logic [LAT-1:0][CW-1:0]  tag_col;
    logic                    adv;
    logic                    push_win;

    // The output register can take a new result whenever it is empty or being drained.
    assign adv      = !m_valid || m_ready;
    assign s_ready  = (state == RUN) && adv;
    assign busy     = (state != IDLE);
    // Clear is tied to the start-accept cycle so it never overlaps a real advance.
    assign dp_clear = (state == IDLE) && start;
    // A pixel closes a window only if it has a row above and a column to its left.
    assign push_win = (state == RUN) && (row != {RW{1'b0}}) && (col != {CW{1'b0}});

    // Datapath strobe: real pixels in RUN, zero-pixel dummies in FLUSH to drain the latency.
    always_comb begin
        dp_en    = 1'b0;
        dp_pixel = {DATA_W{1'b0}};
        case (state)
            RUN: begin
                dp_en    = s_valid && s_ready;
                dp_pixel = s_pixel;
            end
            FLUSH: begin
                dp_en    = adv;
                dp_pixel = {DATA_W{1'b0}};
            end
            default: begin
                dp_en    = 1'b0;
                dp_pixel = {DATA_W{1'b0}};
            end
        endcase
    end

    // Frame FSM, coordinate counters, tag pipe and output result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            done       <= 1'b0;
            row        <= {RW{1'b0}};
            col        <= {CW{1'b0}};
            flush_cnt  <= {FW{1'b0}};
            tag_win    <= {LAT{1'b0}};
            tag_row    <= {(LAT*RW){1'b0}};
            tag_col    <= {(LAT*CW){1'b0}};
            dp_weights <= {(4*DATA_W){1'b0}};
            m_valid    <= 1'b0;
            m_data     <= {RES_W{1'b0}};
            m_row      <= {RW{1'b0}};
            m_col      <= {CW{1'b0}};
        end else begin
            done <= 1'b0;

            if (dp_en && tag_win[LAT-1]) begin
                m_valid <= 1'b1;
                m_data  <= dp_result;
                m_row   <= tag_row[LAT-1];
                m_col   <= tag_col[LAT-1];
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end

            if (dp_en) begin
                for (int i = LAT - 1; i > 0; i--) begin
                    tag_win[i] <= tag_win[i-1];
                    tag_row[i] <= tag_row[i-1];
                    tag_col[i] <= tag_col[i-1];
                end
                tag_win[0] <= push_win;
                tag_row[0] <= row - RW'(1);
                tag_col[0] <= col - CW'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        dp_weights <= w_in;
                        row        <= {RW{1'b0}};
                        col        <= {CW{1'b0}};
                        flush_cnt  <= {FW{1'b0}};
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (dp_en) begin
                        if (col == COL_LAST) begin
                            col <= {CW{1'b0}};
                            row <= row + RW'(1);
                            if (row == ROW_LAST) begin
                                flush_cnt <= {FW{1'b0}};
                                state     <= FLUSH;
                            end
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (dp_en) begin
                        flush_cnt <= flush_cnt + FW'(1);
                        if (flush_cnt == FLUSH_LAST) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!m_valid) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv2x2_frame_ctrl.sv
// tb_conv2x2_frame_ctrl: directed bench with a behavioural 2x2 datapath (LAT=2).
module tb_conv2x2_frame_ctrl;

    localparam int DATA_W = 8;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 4;
    localparam int LAT    = 2;
    localparam int RES_W  = 2 * DATA_W + 5;

    logic                clk = 1'b0;
    logic                rst, start, s_valid, m_ready;
    logic [4*DATA_W-1:0] w_in;
    logic [DATA_W-1:0]   s_pixel;
    logic                busy, done, s_ready, dp_en, dp_clear, m_valid;
    logic [DATA_W-1:0]   dp_pixel;
    logic [4*DATA_W-1:0] dp_weights;
    logic [RES_W-1:0]    dp_result, m_data;
    logic [1:0]          m_row, m_col;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    conv2x2_frame_ctrl #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .w_in(w_in), .busy(busy), .done(done),
        .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel),
        .dp_en(dp_en), .dp_pixel(dp_pixel), .dp_clear(dp_clear), .dp_weights(dp_weights),
        .dp_result(dp_result), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_row(m_row), .m_col(m_col)
    );

    // Behavioural datapath: history of the last IMG_W+1 pixels and a 2-stage result pipe.
    logic [DATA_W-1:0] sr [0:IMG_W];
    logic [RES_W-1:0]  p0, p1;
    assign dp_result = p1;

    function automatic logic [RES_W-1:0] win_sum(input logic [4*DATA_W-1:0] w,
            input logic [DATA_W-1:0] tl, tr, bl, br);
        int a1, a2, a3, a4, s;
        a1 = w[DATA_W-1:0];
        a2 = w[2*DATA_W-1:DATA_W];
        a3 = w[3*DATA_W-1:2*DATA_W];
        a4 = w[4*DATA_W-1:3*DATA_W];
        s = a1 * int'(tl) + a2 * int'(tr) + a3 * int'(bl) + a4 * int'(br);
        return s[RES_W-1:0];
    endfunction

    // Datapath model update.
    always @(posedge clk) begin
        if (rst) begin
            p0 <= '0;
            p1 <= '0;
        end else if (dp_clear) begin
            for (int i = 0; i <= IMG_W; i++) sr[i] <= '0;
        end else if (dp_en) begin
            p0 <= win_sum(dp_weights, sr[IMG_W], sr[IMG_W-1], sr[0], dp_pixel);
            p1 <= p0;
            sr[0] <= dp_pixel;
            for (int i = 1; i <= IMG_W; i++) sr[i] <= sr[i-1];
        end
    end

    // Output monitor: records handshaken results and counts events.
    int res_n = 0, done_n = 0, dpen_n = 0, viol_n = 0;
    logic [RES_W-1:0] res_d [0:255];
    logic [1:0]       res_r [0:255];
    logic [1:0]       res_c [0:255];

    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) begin
                if (res_n < 256) begin
                    res_d[res_n] <= m_data;
                    res_r[res_n] <= m_row;
                    res_c[res_n] <= m_col;
                end
                res_n <= res_n + 1;
            end
            if (done) done_n <= done_n + 1;
            if (dp_en) dpen_n <= dpen_n + 1;
            if (s_ready && m_valid && !m_ready) viol_n <= viol_n + 1;
        end
    end

    int   fr_r0, fr_d0, fr_e0, fr_v0;
    logic fr_timeout, fr_clear;
    int   exp_basic [9] = '{14, 18, 22, 30, 34, 38, 46, 50, 54};

    // Drive one frame: pmode 0 -> pixel idx+1, 1 -> 255; rmode 1 -> m_ready 1-in-3;
    // gmode 1 -> random s_valid gaps; inj 1 -> extra start with other weights mid-frame.
    task automatic run_frame(input logic [4*DATA_W-1:0] w, input int pmode,
                             input int rmode, input int gmode, input int inj);
        int idx, cyc;
        logic acc;
        fr_r0 = res_n; fr_d0 = done_n; fr_e0 = dpen_n; fr_v0 = viol_n;
        w_in = w; start = 1'b1; m_ready = 1'b1;
        @(negedge clk);
        fr_clear = dp_clear;
        @(posedge clk); #1;
        start = 1'b0; w_in = 32'h0505_0505;
        idx = 0; cyc = 0;
        while (done_n == fr_d0 && cyc < 600) begin
            s_valid = (idx < IMG_W * IMG_H) && (gmode == 0 || $urandom_range(0, 2) != 0);
            s_pixel = (pmode == 0) ? DATA_W'(idx + 1) : 8'd255;
            m_ready = (rmode == 0) ? 1'b1 : (cyc % 3 == 0);
            if (inj != 0 && cyc == 5) begin
                start = 1'b1; w_in = 32'h0909_0909;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        s_valid = 1'b0; m_ready = 1'b1; start = 1'b0;
        fr_timeout = (done_n == fr_d0);
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; s_valid = 1'b1; s_pixel = 8'd7; m_ready = 1'b1;
        w_in = 32'h0102_0304;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({busy, done, s_ready, dp_en, dp_clear, m_valid} !== 6'b000000)
            $display("FAIL reset_ctrl got %b want 000000", {busy, done, s_ready, dp_en, dp_clear, m_valid});
        else n_pass++;
        n_chk++;
        if (dp_weights !== 32'h0) $display("FAIL reset_weights got %h want 0", dp_weights);
        else n_pass++;
        n_chk++;
        if ({m_data, m_row, m_col} !== 25'h0) $display("FAIL reset_mout got %h want 0", {m_data, m_row, m_col});
        else n_pass++;
        s_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        run_frame(32'h0101_0101, 0, 0, 0, 0);
        n_chk++;
        if (fr_timeout) $display("FAIL basic_timeout no done within budget");
        else n_pass++;
        n_chk++;
        if (fr_clear !== 1'b1) $display("FAIL basic_clear got %b want 1", fr_clear);
        else n_pass++;
        n_chk++;
        if (res_n - fr_r0 !== 9) $display("FAIL basic_count got %0d want 9", res_n - fr_r0);
        else n_pass++;
        for (int i = 0; i < 9; i++) begin
            n_chk++;
            if (res_d[fr_r0+i] !== RES_W'(exp_basic[i]) || res_r[fr_r0+i] !== 2'(i / 3) || res_c[fr_r0+i] !== 2'(i % 3))
                $display("FAIL basic_res%0d got %0d@(%0d,%0d) want %0d@(%0d,%0d)", i,
                         res_d[fr_r0+i], res_r[fr_r0+i], res_c[fr_r0+i], exp_basic[i], i / 3, i % 3);
            else n_pass++;
        end
        n_chk++;
        if (dpen_n - fr_e0 !== 18) $display("FAIL basic_dpen got %0d want 18", dpen_n - fr_e0);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (done_n - fr_d0 !== 1 || busy !== 1'b0)
            $display("FAIL basic_done got pulses=%0d busy=%b want 1 0", done_n - fr_d0, busy);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        run_frame(32'h0101_0101, 0, 1, 0, 0);
        n_chk++;
        if (fr_timeout || res_n - fr_r0 !== 9)
            $display("FAIL bp_count got %0d timeout=%b want 9", res_n - fr_r0, fr_timeout);
        else n_pass++;
        for (int i = 0; i < 9; i++) begin
            n_chk++;
            if (res_d[fr_r0+i] !== RES_W'(exp_basic[i]) || res_r[fr_r0+i] !== 2'(i / 3) || res_c[fr_r0+i] !== 2'(i % 3))
                $display("FAIL bp_res%0d got %0d@(%0d,%0d) want %0d@(%0d,%0d)", i,
                         res_d[fr_r0+i], res_r[fr_r0+i], res_c[fr_r0+i], exp_basic[i], i / 3, i % 3);
            else n_pass++;
        end
        n_chk++;
        if (viol_n - fr_v0 !== 0) $display("FAIL bp_sready got %0d violations want 0", viol_n - fr_v0);
        else n_pass++;
    endtask

    task automatic test_gaps;
        run_frame(32'h0101_0101, 0, 0, 1, 0);
        n_chk++;
        if (fr_timeout || res_n - fr_r0 !== 9)
            $display("FAIL gap_count got %0d timeout=%b want 9", res_n - fr_r0, fr_timeout);
        else n_pass++;
        for (int i = 0; i < 9; i++) begin
            n_chk++;
            if (res_d[fr_r0+i] !== RES_W'(exp_basic[i]) || res_r[fr_r0+i] !== 2'(i / 3) || res_c[fr_r0+i] !== 2'(i % 3))
                $display("FAIL gap_res%0d got %0d want %0d", i, res_d[fr_r0+i], exp_basic[i]);
            else n_pass++;
        end
        n_chk++;
        if (dpen_n - fr_e0 !== 18) $display("FAIL gap_dpen got %0d want 18", dpen_n - fr_e0);
        else n_pass++;
    endtask

    task automatic test_start_ignored;
        run_frame(32'h0101_0101, 0, 0, 0, 1);
        n_chk++;
        if (fr_timeout || res_n - fr_r0 !== 9)
            $display("FAIL ign_count got %0d timeout=%b want 9", res_n - fr_r0, fr_timeout);
        else n_pass++;
        for (int i = 0; i < 9; i++) begin
            n_chk++;
            if (res_d[fr_r0+i] !== RES_W'(exp_basic[i]))
                $display("FAIL ign_res%0d got %0d want %0d", i, res_d[fr_r0+i], exp_basic[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        int d0, r0;
        d0 = done_n;
        w_in = 32'h0101_0101; start = 1'b1; m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            s_valid = 1'b1; s_pixel = DATA_W'(i + 1);
            @(posedge clk); #1;
        end
        s_valid = 1'b0; rst = 1'b1;
        r0 = res_n;
        @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({m_valid, busy, s_ready} !== 3'b000)
            $display("FAIL rstmid_state got %b want 000", {m_valid, busy, s_ready});
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if (done_n !== d0 || res_n !== r0)
            $display("FAIL rstmid_nodone got done=%0d res=%0d want 0 0", done_n - d0, res_n - r0);
        else n_pass++;
        run_frame(32'h0101_0101, 0, 0, 0, 0);
        n_chk++;
        if (fr_timeout || res_n - fr_r0 !== 9)
            $display("FAIL rstmid_count got %0d timeout=%b want 9", res_n - fr_r0, fr_timeout);
        else n_pass++;
        for (int i = 0; i < 9; i++) begin
            n_chk++;
            if (res_d[fr_r0+i] !== RES_W'(exp_basic[i]) || res_r[fr_r0+i] !== 2'(i / 3) || res_c[fr_r0+i] !== 2'(i % 3))
                $display("FAIL rstmid_res%0d got %0d@(%0d,%0d) want %0d@(%0d,%0d)", i,
                         res_d[fr_r0+i], res_r[fr_r0+i], res_c[fr_r0+i], exp_basic[i], i / 3, i % 3);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        for (int f = 0; f < 2; f++) begin
            run_frame(32'h0403_0201, 1, 0, 0, 0);
            n_chk++;
            if (fr_timeout || res_n - fr_r0 !== 9)
                $display("FAIL b2b_count%0d got %0d timeout=%b want 9", f, res_n - fr_r0, fr_timeout);
            else n_pass++;
            for (int i = 0; i < 9; i++) begin
                n_chk++;
                if (res_d[fr_r0+i] !== 21'd2550 || res_r[fr_r0+i] !== 2'(i / 3) || res_c[fr_r0+i] !== 2'(i % 3))
                    $display("FAIL b2b_res%0d_%0d got %0d@(%0d,%0d) want 2550@(%0d,%0d)", f, i,
                             res_d[fr_r0+i], res_r[fr_r0+i], res_c[fr_r0+i], i / 3, i % 3);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_gaps();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
